// File: rtl/data_memory_sync_if.sv
// Load/store request and response bus between the MEM stage and data_memory_sync.
interface data_memory_sync_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err_align;
    logic        resp_err_range;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err_align, resp_err_range
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err_align, resp_err_range
    );
endinterface

// File: rtl/data_memory_sync.sv
// Clocked MIPS data memory: byte/half/word loads and stores over a valid/ready
// handshake, with programmable wait states and alignment/range error reporting.
module data_memory_sync #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h7FFF0000,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic            clk,
    input  logic            reset,
    data_memory_sync_if.slave bus
);
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam logic [32:0]   LIMIT    = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          accept, commit;

    logic          lat_write, lat_unsigned;
    logic [1:0]    lat_size;
    logic [31:0]   lat_addr, lat_wdata;

    logic          cur_write, cur_unsigned;
    logic [1:0]    cur_size, lane;
    logic [31:0]   cur_addr, cur_wdata, offset;
    logic [AW-1:0] idx;
    logic          in_range, misaligned, ok;

    logic [31:0]   rword, ld_data, wd;
    logic [3:0]    be;
    logic [7:0]    bsel;
    logic [15:0]   hsel;

    logic [31:0]   rdata_q;
    logic          err_align_q, err_range_q;

    logic [31:0]   mem [DEPTH_WORDS] = '{default: '0};

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (WAIT_CYCLES == 0) ? RESP : BUSY;
            BUSY:    if (cnt == '0) state_nxt = RESP;
            RESP:    if (bus.resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = (state == IDLE) && !reset;
        bus.resp_valid = (state == RESP);
    end

    assign accept = bus.req_valid && bus.req_ready;
    assign commit = !reset && (state_nxt == RESP) && (state != RESP);

    always_ff @(posedge clk) begin
        if (reset)                      cnt <= '0;
        else if (state == IDLE && accept) cnt <= CNT_INIT;
        else if (state == BUSY && cnt != '0) cnt <= cnt - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lat_write    <= bus.req_write;
            lat_size     <= bus.req_size;
            lat_unsigned <= bus.req_unsigned;
            lat_addr     <= bus.req_addr;
            lat_wdata    <= bus.req_wdata;
        end
    end

    // With zero wait states the commit edge is the accept edge, so use the live request.
    assign cur_write    = (state == IDLE) ? bus.req_write    : lat_write;
    assign cur_size     = (state == IDLE) ? bus.req_size     : lat_size;
    assign cur_unsigned = (state == IDLE) ? bus.req_unsigned : lat_unsigned;
    assign cur_addr     = (state == IDLE) ? bus.req_addr     : lat_addr;
    assign cur_wdata    = (state == IDLE) ? bus.req_wdata    : lat_wdata;

    // 33-bit compares so addresses below BASE_ADDR cannot wrap into the window.
    assign in_range   = ({1'b0, cur_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, cur_addr} < LIMIT);
    assign misaligned = (cur_size == 2'b11) ||
                        (cur_size == 2'b01 && cur_addr[0]) ||
                        (cur_size == 2'b10 && cur_addr[1:0] != 2'b00);
    assign ok     = in_range && !misaligned;
    assign offset = cur_addr - BASE_ADDR;
    assign idx    = AW'(offset >> 2);
    assign lane   = cur_addr[1:0];
    assign rword  = mem[idx];

    always_comb begin
        be = 4'b1111;
        wd = cur_wdata;
        case (cur_size)
            2'b00: begin be = 4'b0001 << lane;                     wd = {4{cur_wdata[7:0]}};  end
            2'b01: begin be = lane[1] ? 4'b1100 : 4'b0011;         wd = {2{cur_wdata[15:0]}}; end
            default: ;
        endcase
    end

    always_comb begin
        bsel    = rword[{lane, 3'b000} +: 8];
        hsel    = lane[1] ? rword[31:16] : rword[15:0];
        ld_data = rword;
        case (cur_size)
            2'b00:   ld_data = {{24{bsel[7] & ~cur_unsigned}}, bsel};
            2'b01:   ld_data = {{16{hsel[15] & ~cur_unsigned}}, hsel};
            default: ld_data = rword;
        endcase
    end

    always_ff @(posedge clk) begin
        if (commit && ok && cur_write) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q     <= '0;
            err_align_q <= 1'b0;
            err_range_q <= 1'b0;
        end else if (commit) begin
            rdata_q     <= (ok && !cur_write) ? ld_data : '0;
            err_align_q <= misaligned;
            err_range_q <= !in_range;
        end
    end

    assign bus.resp_rdata     = rdata_q;
    assign bus.resp_err_align = err_align_q;
    assign bus.resp_err_range = err_range_q;
endmodule
